inst_axi_read_bridge: RTL and testbench

//   Converts the IF stage's SRAM-like instruction port (req/addr_ok, data_ok/rdata) into AXI4 AR+R reads.

---
 rtl/inst_axi_read_bridge_pkg.sv | 28 ++
 rtl/inst_axi_read_bridge.sv | 194 +++++++++++++++++++
 tb/tb_inst_axi_read_bridge.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/inst_axi_read_bridge_pkg.sv
// -----------------------------------------------------------------------------
// inst_axi_read_bridge_pkg
//   Shared AXI header for the instruction-fetch read bridge: fixed AR payload
//   encodings, the AR FSM state codes and a small size-conversion helper.
//   No ports; imported by inst_axi_read_bridge.
// -----------------------------------------------------------------------------
package inst_axi_read_bridge_pkg;

   // AR payload encodings used by single-beat instruction fetches
   localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
   localparam logic [1:0] AXI_BURST_INCR = 2'b01;
   localparam logic [7:0] AXI_LEN_SINGLE = 8'h00;
   localparam logic [1:0] AXI_LOCK_NORM  = 2'b00;
   localparam logic [3:0] AXI_CACHE_DEV  = 4'h0;
   localparam logic [2:0] AXI_PROT_NONE  = 3'h0;

   // AR channel state: idle (may accept) or holding one AR until arready
   typedef enum logic {
      AR_IDLE = 1'b0,
      AR_BUSY = 1'b1
   } ar_state_t;

   // SRAM-side size (bytes = 2^size) to AXI arsize (same log2 encoding)
   function automatic logic [2:0] size_to_arsize(input logic [1:0] sram_size);
      return {1'b0, sram_size};
   endfunction

endpackage

// File: rtl/inst_axi_read_bridge.sv
// -----------------------------------------------------------------------------
// inst_axi_read_bridge
//   Converts the IF stage's SRAM-like instruction port (req/addr_ok,
//   data_ok/rdata) into single-beat, in-order AXI4 AR+R reads.
//   At most MAX_OUTSTANDING requests are accepted but not yet returned.
//
// Ports
//   clk, resetn                 clock (rising edge), async active-low reset
//   inst_sram_req/wr/size/addr  IF request (wr must be 0; wr=1 never accepted)
//   inst_sram_addr_ok           request accepted this cycle (combinational)
//   inst_sram_data_ok/rdata     one-cycle return pulse with instruction word
//   inst_sram_err               (only with IBRIDGE_RRESP_ERR_EN) beat had
//                               rresp[1]=1, valid alongside data_ok
//   ar*                         AXI read address channel (constant ID/len/burst)
//   r*, rready                  AXI read data channel; rid/rlast are ignored
//
// Configuration macro
//   IBRIDGE_RRESP_ERR_EN  adds inst_sram_err; otherwise rresp is ignored.
// -----------------------------------------------------------------------------
module inst_axi_read_bridge
   import inst_axi_read_bridge_pkg::*;
#(
   parameter int         MAX_OUTSTANDING = 2,
   parameter logic [3:0] ARID_VAL        = 4'h0
) (
   input  logic        clk,
   input  logic        resetn,
   // IF instruction port
   input  logic        inst_sram_req,
   input  logic        inst_sram_wr,
   input  logic [1:0]  inst_sram_size,
   input  logic [31:0] inst_sram_addr,
   output logic        inst_sram_addr_ok,
   output logic        inst_sram_data_ok,
   output logic [31:0] inst_sram_rdata,
   // AXI read address channel
   output logic [3:0]  arid,
   output logic [31:0] araddr,
   output logic [7:0]  arlen,
   output logic [2:0]  arsize,
   output logic [1:0]  arburst,
   output logic [1:0]  arlock,
   output logic [3:0]  arcache,
   output logic [2:0]  arprot,
   output logic        arvalid,
   input  logic        arready,
   // AXI read data channel
   input  logic [3:0]  rid,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rlast,
   input  logic        rvalid,
   output logic        rready
`ifdef IBRIDGE_RRESP_ERR_EN
   ,
   output logic        inst_sram_err
`endif
);

   localparam logic [1:0] MAX_CNT = 2'(MAX_OUTSTANDING);

   ar_state_t   state_reg, state_next;
   logic [1:0]  cnt_reg, cnt_next;
   logic [31:0] addr_reg;
   logic [1:0]  size_reg;
   logic        rready_reg;
   logic        data_ok_reg;
   logic [31:0] rdata_reg;

   logic        room;
   logic        accept;
   logic        beat_take;
   logic        unused_axi;

   // rid (single shared ID), rlast (always single beat) and, without the
   // error option, rresp carry no information for this bridge.
   assign unused_axi = ^{rid, rlast, rresp};

   // ------------------------------------------------------------------------
   // AR FSM: next state and the combinational accept
   // ------------------------------------------------------------------------
   assign room = (cnt_reg < MAX_CNT);

   always_comb begin
      state_next = state_reg;
      accept     = 1'b0;
      unique case (state_reg)
         AR_IDLE: begin
            accept = inst_sram_req & ~inst_sram_wr & room;
            if (accept) begin
               state_next = AR_BUSY;
            end
         end
         AR_BUSY: begin
            if (arready) begin
               state_next = AR_IDLE;
            end
         end
         default: state_next = AR_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_reg <= AR_IDLE;
         addr_reg  <= '0;
         size_reg  <= '0;
      end else begin
         state_reg <= state_next;
         if (accept) begin
            addr_reg <= inst_sram_addr;
            size_reg <= inst_sram_size;
         end
      end
   end

   // ------------------------------------------------------------------------
   // Outstanding counter
   // cnt counts accepted requests whose data_ok has not yet been emitted.
   // A beat registered last cycle (data_ok_reg high) is still inside cnt, so
   // requests still waiting for their beat number cnt - data_ok_reg. A beat
   // arriving when that number is zero has no owner and is dropped.
   // ------------------------------------------------------------------------
   assign beat_take = rvalid & rready_reg & (cnt_reg > {1'b0, data_ok_reg});

   always_comb begin
      cnt_next = cnt_reg;
      unique case ({accept, data_ok_reg})
         2'b10:   cnt_next = cnt_reg + 2'd1;
         2'b01:   cnt_next = cnt_reg - 2'd1;
         default: cnt_next = cnt_reg;
      endcase
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         cnt_reg <= '0;
      end else begin
         cnt_reg <= cnt_next;
      end
   end

   // ------------------------------------------------------------------------
   // R channel: always ready once out of reset; beats are registered and
   // presented to IF as a one-cycle data_ok pulse.
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         rready_reg  <= 1'b0;
         data_ok_reg <= 1'b0;
         rdata_reg   <= '0;
      end else begin
         rready_reg  <= 1'b1;
         data_ok_reg <= beat_take;
         if (beat_take) begin
            rdata_reg <= rdata;
         end
      end
   end

`ifdef IBRIDGE_RRESP_ERR_EN
   logic err_reg;

   // SLVERR and DECERR both have rresp[1] set
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         err_reg <= 1'b0;
      end else if (beat_take) begin
         err_reg <= rresp[1];
      end
   end

   assign inst_sram_err = err_reg;
`endif

   // ------------------------------------------------------------------------
   // Output assignments
   // ------------------------------------------------------------------------
   assign inst_sram_addr_ok = accept;
   assign inst_sram_data_ok = data_ok_reg;
   assign inst_sram_rdata   = rdata_reg;

   assign arid    = ARID_VAL;
   assign araddr  = addr_reg;
   assign arlen   = AXI_LEN_SINGLE;
   assign arsize  = size_to_arsize(size_reg);
   assign arburst = AXI_BURST_INCR;
   assign arlock  = AXI_LOCK_NORM;
   assign arcache = AXI_CACHE_DEV;
   assign arprot  = AXI_PROT_NONE;
   assign arvalid = (state_reg == AR_BUSY);
   assign rready  = rready_reg;

endmodule

// File: tb/tb_inst_axi_read_bridge.sv
// -----------------------------------------------------------------------------
// tb_inst_axi_read_bridge
//   Directed scenarios with literal expectations, then a randomized phase with
//   a randomized AXI slave. A queue-based reference model, updated once per
//   cycle on the falling edge, checks every DUT output every cycle.
// -----------------------------------------------------------------------------
module tb_inst_axi_read_bridge;

   localparam int         MAX  = 2;
   localparam logic [3:0] ARID = 4'h5;

   logic        clk = 1'b0;
   logic        resetn;
   logic        req, wr;
   logic [1:0]  size;
   logic [31:0] addr;
   logic        addr_ok, data_ok;
   logic [31:0] sram_rdata;
   logic [3:0]  arid;
   logic [31:0] araddr;
   logic [7:0]  arlen;
   logic [2:0]  arsize;
   logic [1:0]  arburst, arlock;
   logic [3:0]  arcache;
   logic [2:0]  arprot;
   logic        arvalid, arready;
   logic [3:0]  rid;
   logic [31:0] axi_rdata;
   logic [1:0]  rresp;
   logic        rlast, rvalid, rready;
`ifdef IBRIDGE_RRESP_ERR_EN
   logic        err;
`endif

   inst_axi_read_bridge #(.MAX_OUTSTANDING(MAX), .ARID_VAL(ARID)) dut (
      .clk(clk), .resetn(resetn),
      .inst_sram_req(req), .inst_sram_wr(wr), .inst_sram_size(size),
      .inst_sram_addr(addr), .inst_sram_addr_ok(addr_ok),
      .inst_sram_data_ok(data_ok), .inst_sram_rdata(sram_rdata),
      .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize),
      .arburst(arburst), .arlock(arlock), .arcache(arcache), .arprot(arprot),
      .arvalid(arvalid), .arready(arready),
      .rid(rid), .rdata(axi_rdata), .rresp(rresp), .rlast(rlast),
      .rvalid(rvalid), .rready(rready)
`ifdef IBRIDGE_RRESP_ERR_EN
      , .inst_sram_err(err)
`endif
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h required %h at %0t", name, act, exp, $time);
      end
   endtask

   // ------------------------------------------------------------------------
   // Reference model (falling edge: check, then advance to the next cycle)
   //   ar_q   : accepted requests whose AR has not been handshaken ({size,addr})
   //   unret  : accepted requests still waiting for their R beat
   //   n_out  : accepted requests whose data_ok has not yet been seen
   // ------------------------------------------------------------------------
   logic [33:0] ar_q[$];
   int          unret;
   int          n_out;
   bit          live;
   bit          e_dok;
   logic [31:0] e_rdata;
   bit          e_err;

   always @(negedge clk) begin
      bit e_aok;
      bit beat;
      if (!resetn) begin
         ar_q.delete();
         unret = 0; n_out = 0; live = 0;
         e_dok = 0; e_rdata = '0; e_err = 0;
         chk("rst_arvalid", arvalid, 0);
         chk("rst_data_ok", data_ok, 0);
         chk("rst_rready", rready, 0);
         chk("rst_araddr", araddr, 0);
         chk("rst_rdata", sram_rdata, 0);
         chk("rst_addr_ok", addr_ok, 0);
`ifdef IBRIDGE_RRESP_ERR_EN
         chk("rst_err", err, 0);
`endif
      end else begin
         e_aok = req && !wr && (ar_q.size() == 0) && (n_out < MAX);
         chk("addr_ok", addr_ok, e_aok);
         chk("arvalid", arvalid, ar_q.size() != 0);
         if (ar_q.size() != 0) begin
            chk("araddr", araddr, ar_q[0][31:0]);
            chk("arsize", arsize, {1'b0, ar_q[0][33:32]});
            chk("arlen", arlen, 0);
            chk("arburst", arburst, 1);
            chk("arid", arid, ARID);
            chk("arlock_cache_prot", {arlock, arcache, arprot}, 0);
         end
         chk("rready", rready, live);
         chk("data_ok", data_ok, e_dok);
         if (e_dok) begin
            chk("rdata", sram_rdata, e_rdata);
`ifdef IBRIDGE_RRESP_ERR_EN
            chk("err", err, e_err);
`endif
         end
         // advance
         beat = rvalid && live && (unret > 0);
         if (e_aok) ar_q.push_back({size, addr});
         else if ((ar_q.size() != 0) && arready) void'(ar_q.pop_front());
         n_out = n_out + (e_aok ? 1 : 0) - (e_dok ? 1 : 0);
         unret = unret + (e_aok ? 1 : 0) - (beat ? 1 : 0);
         e_dok = beat;
         if (beat) begin
            e_rdata = axi_rdata;
            e_err   = rresp[1];
         end
         live = 1;
      end
   end

   // ------------------------------------------------------------------------
   // Stimulus
   // ------------------------------------------------------------------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      req = 0; wr = 0; size = 2'h2; addr = '0;
      arready = 0; rvalid = 0; axi_rdata = '0; rresp = 0; rid = 0; rlast = 1;
   endtask

   logic [31:0] s_q[$];

   initial begin
      resetn = 0;
      idle_inputs();
      repeat (3) @(posedge clk);
      #1 resetn = 1;
      step();
      chk("lit_rready_after_reset", rready, 1);

      // 1. single fetch
      req = 1; addr = 32'h1c000000; arready = 1;
      #1 chk("t1_addr_ok", addr_ok, 1);
      step(); req = 0;
      #1;
      chk("t1_arvalid", arvalid, 1);
      chk("t1_araddr", araddr, 32'h1c000000);
      chk("t1_arlen", arlen, 0);
      chk("t1_arsize", arsize, 2);
      step();
      chk("t1_arvalid_done", arvalid, 0);
      rvalid = 1; axi_rdata = 32'h02800413;
      step(); rvalid = 0;
      chk("t1_data_ok", data_ok, 1);
      chk("t1_rdata", sram_rdata, 32'h02800413);
      step();
      chk("t1_data_ok_once", data_ok, 0);

      // 2. AR backpressure
      arready = 0; req = 1; addr = 32'h1c000010;
      #1 chk("t2_addr_ok", addr_ok, 1);
      step(); addr = 32'h1c000014;
      for (int i = 0; i < 5; i++) begin
         #1;
         chk("t2_arvalid_held", arvalid, 1);
         chk("t2_araddr_held", araddr, 32'h1c000010);
         chk("t2_addr_ok_low", addr_ok, 0);
         step();
      end
      req = 0; arready = 1;
      step();
      chk("t2_arvalid_after_hs", arvalid, 0);
      rvalid = 1; axi_rdata = 32'h12345678;
      step(); rvalid = 0;
      chk("t2_data_ok", data_ok, 1);
      step();

      // 3. outstanding limit
      req = 1; addr = 32'h1c000000;
      #1 chk("t3_acc0", addr_ok, 1);
      step(); req = 0;
      step(); req = 1; addr = 32'h1c000004;
      #1 chk("t3_acc1", addr_ok, 1);
      step(); req = 0;
      step(); req = 1; addr = 32'h1c000008;
      for (int i = 0; i < 3; i++) begin
         #1 chk("t3_blocked", addr_ok, 0);
         step();
      end
      rvalid = 1; axi_rdata = 32'hCAFE0000;
      #1 chk("t3_blocked_beat", addr_ok, 0);
      step(); rvalid = 0;
      #1;
      chk("t3_data_ok", data_ok, 1);
      chk("t3_rdata", sram_rdata, 32'hCAFE0000);
      chk("t3_blocked_at_dok", addr_ok, 0);
      step();
      #1 chk("t3_unblocked", addr_ok, 1);
      step(); req = 0;

      // 4. ordering: two beats on consecutive cycles
      rvalid = 1; axi_rdata = 32'hAAAA0001;
      step();
      chk("t4_dok1", data_ok, 1);
      chk("t4_rdata1", sram_rdata, 32'hAAAA0001);
      axi_rdata = 32'hAAAA0002;
      step();
      chk("t4_dok2", data_ok, 1);
      chk("t4_rdata2", sram_rdata, 32'hAAAA0002);
      rvalid = 0;
      step();
      chk("t4_dok_end", data_ok, 0);

      // 5. simultaneous accept and return at cnt=1
      req = 1; addr = 32'h1c000020;
      #1 chk("t5_accA", addr_ok, 1);
      step(); req = 0;
      step(); rvalid = 1; axi_rdata = 32'hB0000001;
      step(); rvalid = 0; req = 1; addr = 32'h1c000024;
      #1;
      chk("t5_dok_same_cycle", data_ok, 1);
      chk("t5_aok_same_cycle", addr_ok, 1);
      step(); req = 0;
      step(); req = 1; addr = 32'h1c000028;
      #1 chk("t5_cnt_stayed_1", addr_ok, 1);
      step(); req = 0;
      step(); req = 1; addr = 32'h1c00002c;
      #1 chk("t5_cnt_now_2", addr_ok, 0);
      req = 0;
      rvalid = 1; axi_rdata = 32'hB0000002;
      step(); axi_rdata = 32'hB0000003;
      step(); rvalid = 0;
      step();

      // reset in the middle of AR_BUSY
      arready = 0; req = 1; addr = 32'h1c000030;
      step(); req = 0;
      #1 chk("t5_busy_arvalid", arvalid, 1);
      resetn = 0;
      #1;
      chk("t5_async_arvalid", arvalid, 0);
      chk("t5_async_data_ok", data_ok, 0);
      chk("t5_async_rready", rready, 0);
      step(); step();
      resetn = 1; arready = 1;
      step();

      // beat with nothing outstanding is dropped and cnt does not underflow
      rvalid = 1; axi_rdata = 32'hDEAD0000;
      step(); rvalid = 0;
      chk("perr_no_data_ok", data_ok, 0);
      req = 1; addr = 32'h1c000040;
      #1 chk("perr_accept_after", addr_ok, 1);
      step(); req = 0;
      step(); rvalid = 1; axi_rdata = 32'h0000BEEF;
      step(); rvalid = 0;
      chk("perr_data_ok", data_ok, 1);
      step();

`ifdef IBRIDGE_RRESP_ERR_EN
      // 6. error response flag
      for (int k = 0; k < 2; k++) begin
         req = 1; addr = 32'h1c000050;
         step(); req = 0;
         step(); rvalid = 1; rresp = (k == 0) ? 2'b10 : 2'b00; axi_rdata = 32'h600D0000;
         step(); rvalid = 0; rresp = 0;
         chk("t6_data_ok", data_ok, 1);
         chk("t6_err", err, (k == 0) ? 1 : 0);
         step();
      end
`endif

      // randomized phase with a randomized AXI slave
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         if (resetn) begin
            if (arvalid && arready) s_q.push_back(araddr);
            if (rvalid && rready && (s_q.size() != 0)) void'(s_q.pop_front());
         end
         @(posedge clk);
         #1;
         if (c >= 1500 && c < 1503) begin
            resetn = 0;
            idle_inputs();
            s_q.delete();
         end else begin
            resetn    = 1;
            req       = ($urandom_range(0, 2) != 0);
            wr        = ($urandom_range(0, 15) == 0);
            size      = 2'h2;
            addr      = {$urandom_range(0, 32'h3FFFFFFF), 2'b00};
            arready   = ($urandom_range(0, 3) != 0);
            rvalid    = (s_q.size() != 0) && ($urandom_range(0, 2) != 0);
            axi_rdata = $urandom;
            rresp     = 2'($urandom);
            rid       = 4'($urandom);
            rlast     = 1'($urandom);
         end
      end

      idle_inputs();
      repeat (4) step();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, got timeout required finish");
      $fatal(1, "timeout");
   end

endmodule
